ac_goto_builder: RTL and testbench
==================================

// Module: ac_goto_builder
// PURPOSE
//  Writer side of the Aho-Corasick goto/match tables. It streams pattern characters and builds the goto trie.
//  - Allocates a new state when a transition is missing; writes the goto RAM entry at address {state,char}.
//  - Marks the final state of each pattern in the match RAM.
//  - Sits ahead of the scan path; the table reader consumes the finished tables once BUSY is low.
// PARAMETERS
//  STATE_W     8    state id width; goto RAM data width
//  CHAR_W      4    character width; goto address = {state,char} = STATE_W+CHAR_W bits
//  MAX_STATES  256  state ids available, root=0 included; must be <= 2**STATE_W
// PORTS
//  CLK          in   1                 clock, rising edge
//  RST          in   1                 synchronous reset, active-low
//  START        in   1                 1-cycle pulse: clear tables and begin a new build
//  CHAR_VALID   in   1                 pattern character valid
//  CHAR_READY   out  1                 builder accepts a character this cycle
//  CHAR         in   CHAR_W            pattern character
//  CHAR_LAST    in   1                 CHAR is the last character of its pattern
//  G_ADDR       out  STATE_W+CHAR_W    goto RAM address
//  G_WE         out  1                 goto RAM write enable
//  G_WDATA      out  STATE_W           goto RAM write data (next state)
//  G_RDATA      in   STATE_W           goto RAM read data, valid 1 cycle after the address
//  M_ADDR       out  STATE_W           match RAM address
//  M_WE         out  1                 match RAM write enable
//  M_WDATA      out  1                 match flag
//  BUSY         out  1                 clear or character processing in progress
//  PATTERN_DONE out  1                 1-cycle pulse: a pattern's final state was marked
//  OVERFLOW     out  1                 sticky: state allocation failed; cleared by START or reset
//  NUM_STATES   out  STATE_W+1         next free state id; equals the number of states in use
// BEHAVIOUR
//  Reset (RST=0 at a clock edge), aborting any operation:
//   - State: IDLE; cur=0; next_free=1.
//   - Outputs: CHAR_READY=0, all WE=0, all addresses/data=0, BUSY=0, PATTERN_DONE=0, OVERFLOW=0, NUM_STATES=1.
//   - Table contents are unspecified until a START-initiated clear completes.
//  Goto entry value 0 means "no transition"; root is never a goto target, so 0 is unambiguous.
//  FSM states:
//   - IDLE: CHAR_READY=0. START -> CLEAR. CHAR_VALID is ignored until the first START.
//   - CLEAR: each cycle writes G_WE=1, G_WDATA=0 at counter addr 0..2**(STATE_W+CHAR_W)-1.
//       M_WE=1, M_WDATA=0 at addr[STATE_W-1:0] while addr < 2**STATE_W.
//       4096 cycles at default parameters. Then cur=0, next_free=1, OVERFLOW=0 -> ACCEPT.
//   - ACCEPT: CHAR_READY=1, BUSY=0. Handshake fires on CHAR_VALID & CHAR_READY;
//       latch CHAR and CHAR_LAST, drive G_ADDR={cur,CHAR} -> WAIT.
//   - WAIT: RAM latency cycle -> DECIDE.
//   - DECIDE:
//       G_RDATA!=0: cur<=G_RDATA.
//       G_RDATA==0 and next_free<MAX_STATES: G_WE=1, G_WDATA=next_free; cur<=next_free; next_free++.
//       G_RDATA==0 and next_free==MAX_STATES: OVERFLOW<=1; no write; cur<=0; -> DRAIN.
//       Non-last character -> ACCEPT; last character -> MARK.
//   - MARK: M_WE=1, M_ADDR=cur, M_WDATA=1; PATTERN_DONE=1; cur<=0 -> ACCEPT.
//   - DRAIN: CHAR_READY=1; discard characters through the one with CHAR_LAST, no table writes,
//       no PATTERN_DONE -> ACCEPT. Later patterns are still built if they need no new states.
//  Throughput: 1 character per 3 cycles (4 for a last character).
//  CHAR_READY is low in IDLE, CLEAR, WAIT, DECIDE and MARK.
//  START outside IDLE/ACCEPT is ignored; START in ACCEPT restarts CLEAR; that cycle's handshake does not fire.
//  Duplicate pattern: re-marking an existing final state is legal; NUM_STATES does not change.
//  Empty pattern is not representable; CHAR_LAST always accompanies a real character.
//  BUSY=1 in CLEAR, WAIT, DECIDE, MARK; 0 in IDLE, ACCEPT, DRAIN.
// STRUCTURE
//  Shared package ac_pkg:
//   - STATE_W, CHAR_W, ROOT_STATE=0, NO_TRANS=0.
//   - FSM state encoding (IDLE, CLEAR, ACCEPT, WAIT, DECIDE, MARK, DRAIN).
//  One sub-module: ac_clear_counter (address sweep plus done flag), reused by a later failure-table builder.
// TESTING  (bench models 1-cycle-read goto RAM and a match RAM)
//  - Reset mid-CLEAR (RST=0 one cycle) -> IDLE; all outputs at reset values; NUM_STATES=1.
//  - START -> exactly 4096 G_WE pulses (addresses 0..4095, data 0), 256 M_WE pulses, then CHAR_READY=1.
//  - Pattern "1,2,3" (last on 3) -> goto{0,1}=1, {1,2}=2, {2,3}=3; match[3]=1; one PATTERN_DONE; NUM_STATES=4.
//  - Then "1,2,5" -> no new write for 1,2; {2,5}=4; match[4]=1; NUM_STATES=5.
//    Then "1,2" -> no goto writes; match[2]=1.
//  - MAX_STATES=4: "1,2,3" fills the table; "4,5" -> OVERFLOW=1; char 5 drained; no PATTERN_DONE.
//    Then "1,2" still marks match[2].
//  - Random CHAR_VALID gaps -> each character accepted exactly once; tables match a reference trie model.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared constants and FSM encoding for the Aho-Corasick table builders.
package ac_pkg;

  localparam int STATE_W    = 8;
  localparam int CHAR_W     = 4;
  localparam int ROOT_STATE = 0;
  localparam int NO_TRANS   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCEPT,
    S_WAIT,
    S_DECIDE,
    S_MARK,
    S_DRAIN
  } ac_state_e;

endpackage

// File: rtl/ac_clear_counter.sv
// Address sweep 0..2**ADDR_W-1 used to zero a table; done marks the final address.
module ac_clear_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              done
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr   <= '0;
      active <= 1'b0;
    end else if (start) begin
      addr   <= '0;
      active <= 1'b1;
    end else if (active) begin
      addr <= addr + 1'b1;
      if (addr == '1) active <= 1'b0;
    end
  end

  assign done = active && (addr == '1);

endmodule

// File: rtl/ac_goto_builder.sv
// Aho-Corasick goto/match table writer: streams pattern characters and grows the trie.
module ac_goto_builder #(
  parameter int STATE_W    = ac_pkg::STATE_W,
  parameter int CHAR_W     = ac_pkg::CHAR_W,
  parameter int MAX_STATES = 256
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic                      CHAR_VALID,
  output logic                      CHAR_READY,
  input  logic [CHAR_W-1:0]         CHAR,
  input  logic                      CHAR_LAST,
  output logic [STATE_W+CHAR_W-1:0] G_ADDR,
  output logic                      G_WE,
  output logic [STATE_W-1:0]        G_WDATA,
  input  logic [STATE_W-1:0]        G_RDATA,
  output logic [STATE_W-1:0]        M_ADDR,
  output logic                      M_WE,
  output logic                      M_WDATA,
  output logic                      BUSY,
  output logic                      PATTERN_DONE,
  output logic                      OVERFLOW,
  output logic [STATE_W:0]          NUM_STATES
);

  import ac_pkg::*;

  localparam int ADDR_W = STATE_W + CHAR_W;
  localparam int NS_W   = STATE_W + 1;
  localparam logic [NS_W-1:0]    MAX_NS = NS_W'(MAX_STATES);
  localparam logic [STATE_W-1:0] ROOT   = STATE_W'(ROOT_STATE);
  localparam logic [STATE_W-1:0] NONE   = STATE_W'(NO_TRANS);

  ac_state_e          state, state_d;
  logic [STATE_W-1:0] cur, cur_d;
  logic [NS_W-1:0]    next_free, next_free_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               last_q, last_d;
  logic               ovf, ovf_d;

  logic               clr_start;
  logic [ADDR_W-1:0]  clr_addr;
  logic               clr_active;
  logic               clr_done;

  ac_clear_counter #(.ADDR_W(ADDR_W)) u_clear (
    .clk    (CLK),
    .rst_n  (RST),
    .start  (clr_start),
    .addr   (clr_addr),
    .active (clr_active),
    .done   (clr_done)
  );

  always_comb begin
    state_d      = state;
    cur_d        = cur;
    next_free_d  = next_free;
    addr_d       = addr_q;
    last_d       = last_q;
    ovf_d        = ovf;
    clr_start    = 1'b0;
    CHAR_READY   = 1'b0;
    G_ADDR       = '0;
    G_WE         = 1'b0;
    G_WDATA      = '0;
    M_ADDR       = '0;
    M_WE         = 1'b0;
    M_WDATA      = 1'b0;
    BUSY         = 1'b0;
    PATTERN_DONE = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          clr_start = 1'b1;
          ovf_d     = 1'b0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        BUSY   = 1'b1;
        G_WE   = clr_active;
        G_ADDR = clr_addr;
        M_WE   = clr_active && (clr_addr[ADDR_W-1:STATE_W] == '0);
        M_ADDR = clr_addr[STATE_W-1:0];
        if (clr_done) begin
          cur_d       = ROOT;
          next_free_d = NS_W'(1);
          ovf_d       = 1'b0;
          state_d     = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        // READY is withheld on a START cycle so no character is lost to the restart
        if (START) begin
          clr_start = 1'b1;
          ovf_d     = 1'b0;
          state_d   = S_CLEAR;
        end else begin
          CHAR_READY = 1'b1;
          G_ADDR     = {cur, CHAR};
          if (CHAR_VALID) begin
            addr_d  = {cur, CHAR};
            last_d  = CHAR_LAST;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        BUSY    = 1'b1;
        G_ADDR  = addr_q;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        BUSY   = 1'b1;
        G_ADDR = addr_q;
        if (G_RDATA != NONE) begin
          cur_d   = G_RDATA;
          state_d = last_q ? S_MARK : S_ACCEPT;
        end else if (next_free < MAX_NS) begin
          G_WE        = 1'b1;
          G_WDATA     = next_free[STATE_W-1:0];
          cur_d       = next_free[STATE_W-1:0];
          next_free_d = next_free + 1'b1;
          state_d     = last_q ? S_MARK : S_ACCEPT;
        end else begin
          // An overflowing last character already ends its pattern: nothing left to drain
          ovf_d   = 1'b1;
          cur_d   = ROOT;
          state_d = last_q ? S_ACCEPT : S_DRAIN;
        end
      end
      S_MARK: begin
        BUSY         = 1'b1;
        M_WE         = 1'b1;
        M_ADDR       = cur;
        M_WDATA      = 1'b1;
        PATTERN_DONE = 1'b1;
        cur_d        = ROOT;
        state_d      = S_ACCEPT;
      end
      S_DRAIN: begin
        CHAR_READY = 1'b1;
        if (CHAR_VALID && CHAR_LAST) state_d = S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      cur       <= ROOT;
      next_free <= NS_W'(1);
      addr_q    <= '0;
      last_q    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      next_free <= next_free_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      ovf       <= ovf_d;
    end
  end

  assign OVERFLOW   = ovf;
  assign NUM_STATES = next_free;

endmodule

// File: tb/tb_ac_goto_builder.sv
// Bench for ac_goto_builder: default instance plus a MAX_STATES=4 instance, RAM models and a write scoreboard.
module tb_ac_goto_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0, sel = 1'b0;
  logic [3:0] ch = '0;

  logic        ready0, g_we0, m_we0, m_wdata0, busy0, pd0, ovf0;
  logic [11:0] g_addr0;
  logic [7:0]  g_wdata0, g_rdata0, m_addr0;
  logic [8:0]  ns0;
  logic        ready1, g_we1, m_we1, m_wdata1, busy1, pd1, ovf1;
  logic [11:0] g_addr1;
  logic [7:0]  g_wdata1, g_rdata1, m_addr1;
  logic [8:0]  ns1;

  ac_goto_builder dut0 (
    .CLK(clk), .RST(rst), .START(start & ~sel), .CHAR_VALID(valid & ~sel), .CHAR_READY(ready0),
    .CHAR(ch), .CHAR_LAST(last), .G_ADDR(g_addr0), .G_WE(g_we0), .G_WDATA(g_wdata0),
    .G_RDATA(g_rdata0), .M_ADDR(m_addr0), .M_WE(m_we0), .M_WDATA(m_wdata0), .BUSY(busy0),
    .PATTERN_DONE(pd0), .OVERFLOW(ovf0), .NUM_STATES(ns0)
  );

  ac_goto_builder #(.MAX_STATES(4)) dut1 (
    .CLK(clk), .RST(rst), .START(start & sel), .CHAR_VALID(valid & sel), .CHAR_READY(ready1),
    .CHAR(ch), .CHAR_LAST(last), .G_ADDR(g_addr1), .G_WE(g_we1), .G_WDATA(g_wdata1),
    .G_RDATA(g_rdata1), .M_ADDR(m_addr1), .M_WE(m_we1), .M_WDATA(m_wdata1), .BUSY(busy1),
    .PATTERN_DONE(pd1), .OVERFLOW(ovf1), .NUM_STATES(ns1)
  );

  logic        o_ready, o_g_we, o_m_we, o_m_wdata, o_busy, o_pd, o_ovf;
  logic [11:0] o_g_addr;
  logic [7:0]  o_g_wdata, o_m_addr;
  logic [8:0]  o_ns;
  assign o_ready   = sel ? ready1   : ready0;
  assign o_g_we    = sel ? g_we1    : g_we0;
  assign o_m_we    = sel ? m_we1    : m_we0;
  assign o_m_wdata = sel ? m_wdata1 : m_wdata0;
  assign o_busy    = sel ? busy1    : busy0;
  assign o_pd      = sel ? pd1      : pd0;
  assign o_ovf     = sel ? ovf1     : ovf0;
  assign o_g_addr  = sel ? g_addr1  : g_addr0;
  assign o_g_wdata = sel ? g_wdata1 : g_wdata0;
  assign o_m_addr  = sel ? m_addr1  : m_addr0;
  assign o_ns      = sel ? ns1      : ns0;

  // RAM models, seeded with garbage so only a real clear leaves them zero
  logic [7:0] goto0 [0:4095];
  logic [7:0] goto1 [0:4095];
  logic       match0 [0:255];
  logic       match1 [0:255];
  bit         filled = 1'b0;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 4096; i++) begin
        goto0[i] <= 8'($urandom_range(1, 255));
        goto1[i] <= 8'($urandom_range(1, 255));
      end
      for (int i = 0; i < 256; i++) begin
        match0[i] <= 1'b1;
        match1[i] <= 1'b1;
      end
      filled <= 1'b1;
    end else begin
      if (g_we0) goto0[g_addr0] <= g_wdata0;
      if (g_we1) goto1[g_addr1] <= g_wdata1;
      if (m_we0) match0[m_addr0] <= m_wdata0;
      if (m_we1) match1[m_addr1] <= m_wdata1;
    end
    g_rdata0 <= goto0[g_addr0];
    g_rdata1 <= goto1[g_addr1];
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    bit          is_m;
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t sb[$];

  logic [7:0] ref_goto [0:4095];
  bit         ref_match [0:255];
  int         ref_cur, ref_next, ref_max;
  bit         ref_ovf, ref_drain;

  task automatic ref_reset();
    for (int i = 0; i < 4096; i++) ref_goto[i] = '0;
    for (int i = 0; i < 256; i++) ref_match[i] = 1'b0;
    ref_cur = 0; ref_next = 1; ref_ovf = 1'b0; ref_drain = 1'b0;
    sb.delete();
  endtask

  task automatic ref_step(input logic [3:0] c, input bit l);
    int  idx;
    wr_t w;
    if (ref_drain) begin
      if (l) ref_drain = 1'b0;
      return;
    end
    idx = ref_cur * 16 + int'(c);
    if (ref_goto[idx] != 0) begin
      ref_cur = int'(ref_goto[idx]);
    end else if (ref_next < ref_max) begin
      w.is_m = 1'b0; w.addr = idx[11:0]; w.data = ref_next[7:0];
      sb.push_back(w);
      ref_goto[idx] = ref_next[7:0];
      ref_cur = ref_next;
      ref_next++;
    end else begin
      ref_ovf = 1'b1;
      ref_cur = 0;
      if (!l) ref_drain = 1'b1;
      return;
    end
    if (l) begin
      w.is_m = 1'b1; w.addr = ref_cur[11:0]; w.data = 8'd1;
      sb.push_back(w);
      ref_match[ref_cur] = 1'b1;
      ref_cur = 0;
    end
  endtask

  bit clr_mon = 1'b0, mon_en = 1'b0;
  int clr_g = 0, clr_m = 0, clr_err = 0, pd_cnt = 0;

  always @(negedge clk) begin
    wr_t e;
    if (clr_mon) begin
      if (o_g_we) begin
        if (o_g_addr != clr_g[11:0] || o_g_wdata != 8'd0) clr_err++;
        clr_g++;
      end
      if (o_m_we) begin
        if (o_m_addr != clr_m[7:0] || o_m_wdata) clr_err++;
        clr_m++;
      end
    end else if (mon_en) begin
      if (o_g_we) begin
        check("goto_write_queued", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("goto_write_kind", 32'(e.is_m), 0);
          check("goto_write_addr", 32'(o_g_addr), 32'(e.addr));
          check("goto_write_data", 32'(o_g_wdata), 32'(e.data));
        end
      end
      if (o_m_we) begin
        check("match_write_queued", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("match_write_kind", 32'(e.is_m), 1);
          check("match_write_addr", 32'(o_m_addr), 32'(e.addr[7:0]));
          check("match_write_data", 32'(o_m_wdata), 1);
          check("match_with_done", 32'(o_pd), 1);
        end
      end
      if (o_pd) pd_cnt++;
    end
  end

  task automatic do_start(input bit count_clear);
    bit seen = 1'b0;
    @(posedge clk); #1;
    clr_g = 0; clr_m = 0; clr_err = 0;
    clr_mon = 1'b1; mon_en = 1'b0;
    ref_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (o_ready) begin
        seen = 1'b1;
        break;
      end
    end
    clr_mon = 1'b0; mon_en = 1'b1;
    check("clear_finished", 32'(seen), 1);
    if (count_clear) begin
      check("clear_goto_writes", clr_g, 4096);
      check("clear_match_writes", clr_m, 256);
      check("clear_addr_data_errors", clr_err, 0);
    end
    check("ready_after_clear", 32'(o_ready), 1);
    check("busy_after_clear", 32'(o_busy), 0);
    check("num_states_after_clear", 32'(o_ns), 1);
    @(posedge clk); #1;
  endtask

  task automatic send_char(input logic [3:0] c, input bit l);
    bit got = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    valid = 1'b1; ch = c; last = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ref_step(c, l);
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
    check("handshake_in_time", 32'(got), 1);
  endtask

  task automatic send_pattern(input logic [3:0] cs[$]);
    for (int i = 0; i < cs.size(); i++) send_char(cs[i], i == cs.size() - 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare_tables(input string tag);
    int bad = 0;
    for (int i = 0; i < 4096; i++)
      if ((sel ? goto1[i] : goto0[i]) !== ref_goto[i]) bad++;
    for (int i = 0; i < 256; i++)
      if ((sel ? match1[i] : match0[i]) !== ref_match[i]) bad++;
    check({tag, "_table_mismatches"}, bad, 0);
    check({tag, "_scoreboard_empty"}, sb.size(), 0);
    check({tag, "_num_states"}, 32'(o_ns), ref_next);
    check({tag, "_overflow"}, 32'(o_ovf), 32'(ref_ovf));
  endtask

  initial begin
    logic [3:0] pat[$];
    int         pd_before;
    ref_max = 256;
    ref_reset();

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_num_states", 32'(o_ns), 1);
    check("rst_overflow", 32'(o_ovf), 0);
    check("rst_g_we", 32'(o_g_we), 0);
    check("rst_g_addr", 32'(o_g_addr), 0);
    check("rst_m_we", 32'(o_m_we), 0);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_clear_busy", 32'(o_busy), 1);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("reset_mid_clear_busy", 32'(o_busy), 0);
    check("reset_mid_clear_ready", 32'(o_ready), 0);
    check("reset_mid_clear_g_we", 32'(o_g_we), 0);
    check("reset_mid_clear_m_we", 32'(o_m_we), 0);
    check("reset_mid_clear_num_states", 32'(o_ns), 1);
    repeat (5) @(negedge clk);
    check("idle_stays_quiet", 32'(o_g_we), 0);

    do_start(1'b1);
    check("cleared_goto_sample", 32'(goto0[12'hABC]), 0);
    check("cleared_match_sample", 32'(match0[200]), 0);

    pd_before = pd_cnt;
    pat = '{4'd1, 4'd2, 4'd3};
    send_pattern(pat);
    check("p123_goto_0_1", 32'(goto0[12'h001]), 1);
    check("p123_goto_1_2", 32'(goto0[12'h012]), 2);
    check("p123_goto_2_3", 32'(goto0[12'h023]), 3);
    check("p123_match_3", 32'(match0[3]), 1);
    check("p123_done_pulses", pd_cnt - pd_before, 1);
    check("p123_num_states", 32'(o_ns), 4);

    pat = '{4'd1, 4'd2, 4'd5};
    send_pattern(pat);
    check("p125_goto_2_5", 32'(goto0[12'h025]), 4);
    check("p125_match_4", 32'(match0[4]), 1);
    check("p125_num_states", 32'(o_ns), 5);

    pat = '{4'd1, 4'd2};
    send_pattern(pat);
    check("p12_match_2", 32'(match0[2]), 1);
    check("p12_num_states", 32'(o_ns), 5);

    pat = '{4'd1, 4'd2, 4'd3};
    send_pattern(pat);
    check("dup_num_states", 32'(o_ns), 5);

    for (int p = 0; p < 12; p++) begin
      pat.delete();
      repeat ($urandom_range(1, 4)) pat.push_back(4'($urandom_range(0, 15)));
      send_pattern(pat);
    end
    compare_tables("random");

    sel = 1'b1;
    ref_max = 4;
    do_start(1'b0);
    pat = '{4'd1, 4'd2, 4'd3};
    send_pattern(pat);
    check("max_fill_num_states", 32'(o_ns), 4);
    check("max_fill_overflow", 32'(o_ovf), 0);
    pd_before = pd_cnt;
    pat = '{4'd4, 4'd5};
    send_pattern(pat);
    check("max_overflow_set", 32'(o_ovf), 1);
    check("max_overflow_no_done", pd_cnt - pd_before, 0);
    check("max_overflow_no_goto", 32'(goto1[12'h004]), 0);
    check("max_overflow_num_states", 32'(o_ns), 4);
    pd_before = pd_cnt;
    pat = '{4'd1, 4'd2};
    send_pattern(pat);
    check("max_later_match_2", 32'(match1[2]), 1);
    check("max_later_done", pd_cnt - pd_before, 1);
    compare_tables("max");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
